// File: rtl/bcd_hex_counter_display_pkg.sv
// Shared constants for the multi-digit up/down counter: digit limits, the
// active-low seven-segment glyph table and the direction encoding.
package bcd_hex_counter_display_pkg;

    localparam logic [3:0] DIGIT_MAX_HEX = 4'hF;
    localparam logic [3:0] DIGIT_MAX_BCD = 4'd9;

    // Index n holds the a..g pattern (a in bit 6) for digit value n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // d
        7'b0110001,  // C
        7'b1100000,  // b
        7'b0001000,  // A
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    function automatic logic [3:0] digit_max(input logic bcd);
        return bcd ? DIGIT_MAX_BCD : DIGIT_MAX_HEX;
    endfunction

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        return SEG_TABLE[digit];
    endfunction

endpackage

// File: rtl/bcd_hex_counter_display_if.sv
// Control, data and display bundle between the board inputs/HEX displays
// and the counter core.
interface bcd_hex_counter_display_if #(
    parameter int DIGITS = 4
);
    logic                  Enable;
    logic                  Up;
    logic                  Load;
    logic [4*DIGITS-1:0]   LoadValue;
    logic [4*DIGITS-1:0]   Q;
    logic                  Carry;
    logic [7*DIGITS-1:0]   Segments;

    modport master (
        output Enable, Up, Load, LoadValue,
        input  Q, Carry, Segments
    );

    modport slave (
        input  Enable, Up, Load, LoadValue,
        output Q, Carry, Segments
    );
endinterface

// File: rtl/bcd_hex_counter_display_counter_digit.sv
// One 4-bit counter digit: computes its next value and the carry/borrow
// handed to the next more significant digit. Purely combinational.
module counter_digit
    import bcd_hex_counter_display_pkg::*;
#(
    parameter bit BCD = 1'b0
) (
    input  logic       up_i,
    input  logic       cin_i,
    input  logic       load_i,
    input  logic [3:0] load_data_i,
    input  logic [3:0] digit_i,
    output logic [3:0] next_o,
    output logic       cout_o
);
    localparam logic [3:0] MAX = digit_max(BCD);

    logic at_max;
    logic at_zero;
    dir_e dir;

    assign dir     = dir_e'(up_i);
    assign at_max  = (digit_i == MAX);
    assign at_zero = (digit_i == 4'd0);

    // Carry/borrow only propagates when every lower digit is also at its limit.
    assign cout_o = cin_i & ((dir == DIR_UP) ? at_max : at_zero);

    always_comb begin
        next_o = digit_i;
        if (load_i) begin
            next_o = (load_data_i > MAX) ? MAX : load_data_i;
        end else if (cin_i) begin
            if (dir == DIR_UP) begin
                next_o = at_max ? 4'd0 : digit_i + 4'd1;
            end else begin
                next_o = at_zero ? MAX : digit_i - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_hex_counter_display.sv
// Parametrised hex/BCD up/down counter with load, wrap-or-saturate limits,
// terminal-count flag and active-low seven-segment output per digit.
module bcd_hex_counter_display
    import bcd_hex_counter_display_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int BCD      = 0,
    parameter int SATURATE = 0
) (
    input  logic                          Clock,
    input  logic                          Clear,
    bcd_hex_counter_display_if.slave      bus
);
    localparam bit IS_BCD = (BCD != 0);
    localparam bit IS_SAT = (SATURATE != 0);

    logic [4*DIGITS-1:0] q_q;
    logic [4*DIGITS-1:0] q_d;
    logic [4*DIGITS-1:0] next_w;
    logic                carry_q;
    logic                carry_d;
    logic [DIGITS:0]     chain;
    logic                at_limit;

    // chain[i] is the count enable into digit i; chain[DIGITS] means the
    // whole counter sits at its limit for the current direction.
    assign chain[0] = bus.Enable;
    assign at_limit = chain[DIGITS];

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        counter_digit #(
            .BCD (IS_BCD)
        ) u_digit (
            .up_i        (bus.Up),
            .cin_i       (chain[g]),
            .load_i      (bus.Load),
            .load_data_i (bus.LoadValue[4*g +: 4]),
            .digit_i     (q_q[4*g +: 4]),
            .next_o      (next_w[4*g +: 4]),
            .cout_o      (chain[g+1])
        );

        assign bus.Segments[7*g +: 7] = seg_encode(q_q[4*g +: 4]);
    end

    always_comb begin
        q_d     = q_q;
        carry_d = 1'b0;
        if (bus.Load) begin
            q_d = next_w;
        end else if (bus.Enable) begin
            carry_d = at_limit;
            if (!(at_limit && IS_SAT)) begin
                q_d = next_w;
            end
        end
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            q_q     <= '0;
            carry_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            carry_q <= carry_d;
        end
    end

    assign bus.Q     = q_q;
    assign bus.Carry = carry_q;

endmodule

// File: tb/tb_bcd_hex_counter_display.sv
// Scoreboard bench: three counter configurations share one stimulus stream;
// an arithmetic reference model predicts each edge, a monitor compares.
module tb_bcd_hex_counter_display;

    logic        Clock = 1'b0;
    logic        Clear = 1'b1;
    logic        en    = 1'b0;
    logic        up    = 1'b1;
    logic        ld    = 1'b0;
    logic [31:0] lv    = '0;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    // hex: 4 digits wrap; bcd: 3 digits wrap; sat: 2 hex digits saturate
    bcd_hex_counter_display_if #(.DIGITS(4)) ifh ();
    bcd_hex_counter_display_if #(.DIGITS(3)) ifb ();
    bcd_hex_counter_display_if #(.DIGITS(2)) ifs ();

    assign ifh.Enable = en;  assign ifh.Up = up;  assign ifh.Load = ld;  assign ifh.LoadValue = lv[15:0];
    assign ifb.Enable = en;  assign ifb.Up = up;  assign ifb.Load = ld;  assign ifb.LoadValue = lv[11:0];
    assign ifs.Enable = en;  assign ifs.Up = up;  assign ifs.Load = ld;  assign ifs.LoadValue = lv[7:0];

    bcd_hex_counter_display #(.DIGITS(4), .BCD(0), .SATURATE(0)) u_hex (.Clock(Clock), .Clear(Clear), .bus(ifh));
    bcd_hex_counter_display #(.DIGITS(3), .BCD(1), .SATURATE(0)) u_bcd (.Clock(Clock), .Clear(Clear), .bus(ifb));
    bcd_hex_counter_display #(.DIGITS(2), .BCD(0), .SATURATE(1)) u_sat (.Clock(Clock), .Clear(Clear), .bus(ifs));

    typedef struct packed {
        logic [31:0] q;
        logic        c;
    } st_t;

    typedef struct packed {
        logic [15:0] qh; logic ch; logic [27:0] sh;
        logic [11:0] qb; logic cb; logic [20:0] sb;
        logic [7:0]  qs; logic cs; logic [13:0] ss;
    } exp_t;

    exp_t sbq[$];
    st_t  mh, mb, ms;

    logic [6:0] glyph [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: treat Q as one number in radix 10 or 16 and do plain arithmetic.
    function automatic st_t model(st_t s, int n, bit bcd, bit sat,
                                  bit e, bit u, bit l, logic [31:0] v);
        st_t    r;
        longint radix, val, p, d;
        r     = s;
        radix = bcd ? 10 : 16;
        if (l) begin
            r.q = '0;
            for (int i = 0; i < n; i++) begin
                d = longint'((v >> (4*i)) & 32'hF);
                if (bcd && d > 9) d = 9;
                r.q = r.q | (32'(d) << (4*i));
            end
            r.c = 1'b0;
            return r;
        end
        if (!e) begin
            r.c = 1'b0;
            return r;
        end
        val = 0;
        p   = 1;
        for (int i = 0; i < n; i++) begin
            val += longint'((s.q >> (4*i)) & 32'hF) * p;
            p   *= radix;
        end
        if (u) begin
            if (val == p - 1) begin val = sat ? p - 1 : 0; r.c = 1'b1; end
            else begin val++; r.c = 1'b0; end
        end else begin
            if (val == 0) begin val = sat ? 0 : p - 1; r.c = 1'b1; end
            else begin val--; r.c = 1'b0; end
        end
        r.q = '0;
        for (int i = 0; i < n; i++) begin
            r.q = r.q | (32'(val % radix) << (4*i));
            val = val / radix;
        end
        return r;
    endfunction

    function automatic logic [55:0] segs(logic [31:0] q, int n);
        logic [55:0] s;
        s = '0;
        for (int i = 0; i < n; i++)
            s = s | (56'(glyph[(q >> (4*i)) & 32'hF]) << (7*i));
        return s;
    endfunction

    task automatic cycle(bit e, bit u, bit l, logic [31:0] v);
        exp_t        x;
        logic [55:0] t;
        @(negedge Clock);
        Clear = 1'b0;
        en = e; up = u; ld = l; lv = v;
        mh = model(mh, 4, 1'b0, 1'b0, e, u, l, v);
        mb = model(mb, 3, 1'b1, 1'b0, e, u, l, v);
        ms = model(ms, 2, 1'b0, 1'b1, e, u, l, v);
        x.qh = mh.q[15:0]; x.ch = mh.c; t = segs(mh.q, 4); x.sh = t[27:0];
        x.qb = mb.q[11:0]; x.cb = mb.c; t = segs(mb.q, 3); x.sb = t[20:0];
        x.qs = ms.q[7:0];  x.cs = ms.c; t = segs(ms.q, 2); x.ss = t[13:0];
        sbq.push_back(x);
    endtask

    task automatic after_edge();
        @(posedge Clock);
        #2;
    endtask

    task automatic do_clear();
        @(negedge Clock);
        en = 1'b1; up = 1'b1; ld = 1'b1; lv = 32'hFFFF_FFFF;
        Clear = 1'b1;
        #1;
        chk("clear_hex_q",   32'(ifh.Q), 32'h0);
        chk("clear_hex_c",   32'(ifh.Carry), 32'h0);
        chk("clear_hex_seg", 32'(ifh.Segments), 32'({4{7'b0000001}}));
        chk("clear_bcd_q",   32'(ifb.Q), 32'h0);
        chk("clear_sat_q",   32'(ifs.Q), 32'h0);
        mh = '0; mb = '0; ms = '0;
        after_edge();
        chk("clear_hold_hex_q", 32'(ifh.Q), 32'h0);
        chk("clear_hold_hex_c", 32'(ifh.Carry), 32'h0);
    endtask

    function automatic logic [31:0] pick_lv();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            2:       return 32'($urandom_range(0, 3));
            default: return 32'h9999_9999 - 32'($urandom_range(0, 3));
        endcase
    endfunction

    task automatic random_cycles(int n);
        for (int i = 0; i < n; i++)
            cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 15) == 0, pick_lv());
    endtask

    // Monitor: one expected entry per active edge outside Clear.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clock);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("hex_q",   32'(ifh.Q),        32'(e.qh));
                chk("hex_c",   32'(ifh.Carry),    32'(e.ch));
                chk("hex_seg", 32'(ifh.Segments), 32'(e.sh));
                chk("bcd_q",   32'(ifb.Q),        32'(e.qb));
                chk("bcd_c",   32'(ifb.Carry),    32'(e.cb));
                chk("bcd_seg", 32'(ifb.Segments), 32'(e.sb));
                chk("sat_q",   32'(ifs.Q),        32'(e.qs));
                chk("sat_c",   32'(ifs.Carry),    32'(e.cs));
                chk("sat_seg", 32'(ifs.Segments), 32'(e.ss));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mh = '0; mb = '0; ms = '0;
        repeat (2) @(negedge Clock);
        chk("reset_hex_q",   32'(ifh.Q), 32'h0);
        chk("reset_hex_c",   32'(ifh.Carry), 32'h0);
        chk("reset_hex_seg", 32'(ifh.Segments), 32'({4{7'b0000001}}));

        // Clear mid-count from 1234
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_1234);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        after_edge();
        chk("pre_clear_hex_q", 32'(ifh.Q), 32'h1235);
        do_clear();

        // Wrap through all-F on the hex counter
        cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        after_edge();
        chk("wrap_hex_ffff", 32'(ifh.Q), 32'hFFFF);
        chk("wrap_hex_c0",   32'(ifh.Carry), 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        after_edge();
        chk("wrap_hex_0000", 32'(ifh.Q), 32'h0000);
        chk("wrap_hex_c1",   32'(ifh.Carry), 32'h1);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        after_edge();
        chk("wrap_hex_0001", 32'(ifh.Q), 32'h0001);
        chk("wrap_hex_c2",   32'(ifh.Carry), 32'h0);

        // BCD carry across two digits and borrow back
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_0099);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        after_edge();
        chk("bcd_099_up", 32'(ifb.Q), 32'h100);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        after_edge();
        chk("bcd_100_dn", 32'(ifb.Q), 32'h099);

        // BCD load clamp
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_00AF);
        after_edge();
        chk("bcd_clamp_q",   32'(ifb.Q), 32'h099);
        chk("bcd_clamp_seg", 32'(ifb.Segments[13:0]), 32'({2{7'b0000100}}));

        // Saturate at zero counting down
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0);
            after_edge();
            chk("sat_hold_q", 32'(ifs.Q), 32'h00);
            chk("sat_hold_c", 32'(ifs.Carry), 32'h1);
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        after_edge();
        chk("sat_idle_c", 32'(ifs.Carry), 32'h0);

        // Load beats Enable, then hold
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0042);
        after_edge();
        chk("load_win_q", 32'(ifh.Q), 32'h0042);
        chk("load_win_c", 32'(ifh.Carry), 32'h0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
        after_edge();
        chk("hold_q", 32'(ifh.Q), 32'h0042);

        random_cycles(400);
        do_clear();
        random_cycles(150);

        repeat (3) @(negedge Clock);
        chk("sb_drained", 32'(sbq.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
